// File: rtl/gpio_timer_io.sv
// gpio_timer_io
//   I/O peripheral for the RISC5 IO space. It provides an N-bit GPIO port with
//   direction control, atomic set/clear, and rise/fall edge capture into a
//   sticky event register. It also provides a millisecond timer with a
//   loadable count and a compare-match flag, plus one registered level
//   interrupt. All state advances only on cycles where enable is high; reset
//   is synchronous, active-low, and applies regardless of enable.
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active-low
//   enable    clock enable for all state
//   sel       IO window select (top-level decode)
//   adr[3:0]  local word address
//   wr        write strobe, qualified by sel & enable
//   rd        read strobe; reads have no side effects, so it is not used
//   wdata     write data
//   rdata     read data, combinational from adr; zero when sel is low
//   gpio_in   asynchronous pad inputs
//   gpio_out  pad output values
//   gpio_oe   pad output enables (1 = drive)
//   irq       registered interrupt request
//
// Register map (bits above W read 0 and are ignored on write)
//   0 DATA  R synced input / W gpio_out     5 FALL falling-edge mask
//   1 DIR   gpio_oe                          6 EV   pending events, W1C
//   2 SET   R gpio_out / W OR into gpio_out  7 MS   ms counter (write clears pre)
//   3 CLR   R gpio_out / W clear bits        8 CMP  compare value
//   4 RISE  rising-edge mask                 9 TS   bit0 match (W1C), bit1 irq en
module gpio_timer_io #(
   parameter int W        = 8,
   parameter int TICK_DIV = 25000,
   parameter int SYNC     = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic         sel,
   input  logic [3:0]   adr,
   input  logic         wr,
   input  logic         rd,
   input  logic [31:0]  wdata,
   output logic [31:0]  rdata,
   input  logic [W-1:0] gpio_in,
   output logic [W-1:0] gpio_out,
   output logic [W-1:0] gpio_oe,
   output logic         irq
);

   localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic [W-1:0]     sync_q [SYNC];
   logic [W-1:0]     prev_q;
   logic [W-1:0]     rise_q;
   logic [W-1:0]     fall_q;
   logic [W-1:0]     ev_q;
   logic [31:0]      ms_q;
   logic [31:0]      cmp_q;
   logic [PRE_W-1:0] pre_q;
   logic             match_q;
   logic             tie_q;

   logic [W-1:0]     s;
   logic [W-1:0]     wd;
   logic [W-1:0]     ev_set;
   logic [W-1:0]     ev_clr;
   logic             we;
   logic             ms_wr;
   logic             ts_wr;
   logic             tick;
   logic [31:0]      ms_next;
   logic             match_set;
   logic             unused_ok;

   // Reads are side-effect free, so the read strobe carries no information.
   assign unused_ok = ^{rd, wdata};

   assign s      = sync_q[SYNC-1];
   assign wd     = wdata[W-1:0];
   assign we     = sel & wr & enable;
   assign ms_wr  = we & (adr == 4'd7);
   assign ts_wr  = we & (adr == 4'd9);
   assign ev_clr = (we & (adr == 4'd6)) ? wd : '0;

   // Edge detection uses the masks as they stand now, so enabling a mask
   // later never flags an edge that already went by.
   assign ev_set = (rise_q & s & ~prev_q) | (fall_q & ~s & prev_q);

   assign tick = (pre_q == PRE_LAST);

   // A software load of MS wins over a coincident tick.
   assign ms_next   = ms_wr ? wdata : (tick ? ms_q + 32'd1 : ms_q);
   assign match_set = (ms_wr | tick) & (ms_next == cmp_q);

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
         prev_q   <= '0;
         gpio_out <= '0;
         gpio_oe  <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         ev_q     <= '0;
         ms_q     <= '0;
         pre_q    <= '0;
         cmp_q    <= '1;
         match_q  <= 1'b0;
         tie_q    <= 1'b0;
         irq      <= 1'b0;
      end else if (enable) begin
         sync_q[0] <= gpio_in;
         for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= s;

         // New events win over a same-cycle write-1-to-clear.
         ev_q <= (ev_q & ~ev_clr) | ev_set;

         pre_q   <= (ms_wr | tick) ? '0 : pre_q + 1'b1;
         ms_q    <= ms_next;
         match_q <= match_set | (match_q & ~(ts_wr & wdata[0]));

         irq <= (|ev_q) | (match_q & tie_q);

         if (we) begin
            case (adr)
               4'd0:    gpio_out <= wd;
               4'd1:    gpio_oe  <= wd;
               4'd2:    gpio_out <= gpio_out | wd;
               4'd3:    gpio_out <= gpio_out & ~wd;
               4'd4:    rise_q   <= wd;
               4'd5:    fall_q   <= wd;
               4'd8:    cmp_q    <= wdata;
               4'd9:    tie_q    <= wdata[1];
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (sel) begin
         case (adr)
            4'd0:    rdata = 32'(s);
            4'd1:    rdata = 32'(gpio_oe);
            4'd2:    rdata = 32'(gpio_out);
            4'd3:    rdata = 32'(gpio_out);
            4'd4:    rdata = 32'(rise_q);
            4'd5:    rdata = 32'(fall_q);
            4'd6:    rdata = 32'(ev_q);
            4'd7:    rdata = ms_q;
            4'd8:    rdata = cmp_q;
            4'd9:    rdata = {30'd0, tie_q, match_q};
            default: rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_timer_io.sv
module tb_gpio_timer_io;

   localparam int W  = 8;
   localparam int TD = 4;
   localparam int SY = 2;

   logic         clk     = 1'b0;
   logic         rst     = 1'b0;
   logic         enable  = 1'b0;
   logic         sel     = 1'b0;
   logic         wr      = 1'b0;
   logic         rd      = 1'b0;
   logic [3:0]   adr     = '0;
   logic [31:0]  wdata   = '0;
   logic [31:0]  rdata;
   logic [W-1:0] gpio_in = '0;
   logic [W-1:0] gpio_out;
   logic [W-1:0] gpio_oe;
   logic         irq;
   logic [W-1:0] pad     = '0;

   int total = 0;
   int bad   = 0;

   gpio_timer_io #(.W(W), .TICK_DIV(TD), .SYNC(SY)) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .sel      (sel),
      .adr      (adr),
      .wr       (wr),
      .rd       (rd),
      .wdata    (wdata),
      .rdata    (rdata),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .gpio_oe  (gpio_oe),
      .irq      (irq)
   );

   always #50 clk = ~clk;

   // Reference model: register contents, a pad history of sampled values,
   // and the timer expressed as load value plus elapsed enabled cycles.
   logic [W-1:0] m_out, m_oe, m_rise, m_fall, m_ev;
   logic [W-1:0] m_hist [SY+1];
   logic [31:0]  m_cmp, m_base;
   longint       m_cnt;
   logic         m_flag, m_ie, m_irq;

   function automatic logic [31:0] m_ms();
      return m_base + 32'(m_cnt / TD);
   endfunction

   function automatic logic [31:0] exp_reg(int a);
      case (a)
         0:       return 32'(m_hist[SY-1]);
         1:       return 32'(m_oe);
         2, 3:    return 32'(m_out);
         4:       return 32'(m_rise);
         5:       return 32'(m_fall);
         6:       return 32'(m_ev);
         7:       return m_ms();
         8:       return m_cmp;
         9:       return {30'd0, m_ie, m_flag};
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_step();
      logic [W-1:0] s, p, evs, clr;
      logic [31:0]  ms_old, ms_new, cmp_old;
      logic         mw, fclr, match;
      if (!rst) begin
         m_out = '0; m_oe = '0; m_rise = '0; m_fall = '0; m_ev = '0;
         for (int i = 0; i <= SY; i++) m_hist[i] = '0;
         m_cmp = '1; m_base = '0; m_cnt = 0;
         m_flag = 1'b0; m_ie = 1'b0; m_irq = 1'b0;
      end else if (enable) begin
         s       = m_hist[SY-1];
         p       = m_hist[SY];
         evs     = (m_rise & s & ~p) | (m_fall & ~s & p);
         ms_old  = m_ms();
         cmp_old = m_cmp;
         m_irq   = (|m_ev) | (m_flag & m_ie);
         for (int i = SY; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = gpio_in;
         clr  = '0;
         mw   = 1'b0;
         fclr = 1'b0;
         if (sel && wr) begin
            case (adr)
               4'd0: m_out  = wdata[W-1:0];
               4'd1: m_oe   = wdata[W-1:0];
               4'd2: m_out  = m_out | wdata[W-1:0];
               4'd3: m_out  = m_out & ~wdata[W-1:0];
               4'd4: m_rise = wdata[W-1:0];
               4'd5: m_fall = wdata[W-1:0];
               4'd6: clr    = wdata[W-1:0];
               4'd7: mw     = 1'b1;
               4'd8: m_cmp  = wdata;
               4'd9: begin fclr = wdata[0]; m_ie = wdata[1]; end
               default: ;
            endcase
         end
         m_ev = (m_ev & ~clr) | evs;
         if (mw) begin
            m_base = wdata;
            m_cnt  = 0;
         end else begin
            m_cnt++;
         end
         ms_new = m_ms();
         match  = (mw || ms_new != ms_old) && ms_new == cmp_old;
         m_flag = match | (m_flag & ~fclr);
      end
   endtask

   task automatic check_all();
      chk("gpio_out", 32'(gpio_out), 32'(m_out));
      chk("gpio_oe", 32'(gpio_oe), 32'(m_oe));
      chk("irq", 32'(irq), 32'(m_irq));
      sel = 1'b1;
      wr  = 1'b0;
      for (int a = 0; a < 10; a++) begin
         adr = 4'(a);
         #1;
         chk($sformatf("rd%0d", a), rdata, exp_reg(a));
      end
      adr = 4'd12;
      #1;
      chk("rd12", rdata, 32'd0);
      sel = 1'b0;
      adr = 4'd7;
      #1;
      chk("nosel", rdata, 32'd0);
   endtask

   task automatic cyc(input bit r, input bit en, input bit s, input bit w,
                      input logic [3:0] a, input logic [31:0] d, input logic [W-1:0] pv);
      rst = r; enable = en; sel = s; wr = w; adr = a; wdata = d; gpio_in = pv;
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic wreg(input logic [3:0] a, input logic [31:0] d);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, a, d, pad);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, pad);
   endtask

   task automatic rdexp(input string tag, input logic [3:0] a, input logic [31:0] e);
      sel = 1'b1;
      wr  = 1'b0;
      adr = a;
      #1;
      chk(tag, rdata, e);
   endtask

   initial begin
      // Reset
      pad = '0;
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, pad);
      chk("rst_oe", 32'(gpio_oe), 32'd0);
      chk("rst_out", 32'(gpio_out), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      rdexp("rst_ts", 4'd9, 32'd0);
      rdexp("rst_cmp", 4'd8, 32'hFFFF_FFFF);

      // GPIO data path
      wreg(4'd0, 32'hFFFF_FFA5);
      wreg(4'd2, 32'h0000_000A);
      wreg(4'd3, 32'h0000_0081);
      chk("out_2e", 32'(gpio_out), 32'h2E);
      wreg(4'd1, 32'h0000_00F0);
      chk("oe_f0", 32'(gpio_oe), 32'hF0);

      // Rising edge capture and latency
      wreg(4'd4, 32'h1);
      pad = 8'h01;
      idle(2);
      rdexp("ev_early", 4'd6, 32'd0);
      idle(1);
      rdexp("ev_set", 4'd6, 32'h1);
      chk("irq_early", 32'(irq), 32'd0);
      idle(1);
      chk("irq_ev", 32'(irq), 32'd1);
      wreg(4'd6, 32'h1);
      rdexp("ev_clr1", 4'd6, 32'd0);
      pad = 8'h00;
      idle(3);
      pad = 8'h01;
      idle(2);
      wreg(4'd6, 32'h1);
      rdexp("ev_race", 4'd6, 32'h1);
      wreg(4'd6, 32'h1);
      rdexp("ev_clr2", 4'd6, 32'd0);
      idle(1);
      chk("irq_drop", 32'(irq), 32'd0);

      // Timer, compare match, wrap
      wreg(4'd8, 32'd3);
      wreg(4'd7, 32'd2);
      idle(3);
      rdexp("ms_2", 4'd7, 32'd2);
      idle(1);
      rdexp("ms_3", 4'd7, 32'd3);
      rdexp("match", 4'd9, 32'd1);
      wreg(4'd9, 32'd2);
      idle(1);
      chk("irq_tmr", 32'(irq), 32'd1);
      wreg(4'd9, 32'd1);
      idle(1);
      chk("irq_tmr_off", 32'(irq), 32'd0);
      wreg(4'd7, 32'hFFFF_FFFF);
      idle(3);
      rdexp("ms_max", 4'd7, 32'hFFFF_FFFF);
      idle(1);
      rdexp("ms_wrap", 4'd7, 32'd0);

      // Enable low: nothing may move
      for (int n = 0; n < 10; n++) begin
         pad = ~pad;
         cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'($urandom_range(0, 9)), $urandom, pad);
      end

      // Reset while enable is low
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, pad);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, pad);
      chk("rst2_oe", 32'(gpio_oe), 32'd0);
      chk("rst2_out", 32'(gpio_out), 32'd0);
      rdexp("rst2_rise", 4'd4, 32'd0);
      rdexp("rst2_ms", 4'd7, 32'd0);
      rdexp("rst2_cmp", 4'd8, 32'hFFFF_FFFF);

      // Unmapped address
      wreg(4'd1, 32'hFF);
      wreg(4'd0, 32'h3C);
      wreg(4'd12, 32'hFFFF_FFFF);
      chk("unmap_out", 32'(gpio_out), 32'h3C);
      chk("unmap_oe", 32'(gpio_oe), 32'hFF);
      rdexp("unmap_rd", 4'd12, 32'd0);

      // Randomized traffic against the model
      wreg(4'd4, 32'h5A);
      wreg(4'd5, 32'hC3);
      for (int n = 0; n < 400; n++) begin
         bit          r, en, s, w;
         logic [3:0]  a;
         logic [31:0] d;
         r  = ($urandom_range(0, 99) != 0);
         en = ($urandom_range(0, 99) < 85);
         s  = ($urandom_range(0, 99) < 80);
         w  = 1'($urandom_range(0, 1));
         a  = 4'($urandom_range(0, 15));
         d  = $urandom;
         if (a == 4'd7 || a == 4'd8) d = 32'($urandom_range(0, 12));
         if (a == 4'd7 && $urandom_range(0, 9) == 0) d = 32'hFFFF_FFFE;
         if ($urandom_range(0, 2) == 0) pad = pad ^ W'(1 << $urandom_range(0, W-1));
         rd = 1'($urandom_range(0, 1));
         cyc(r, en, s, w, a, d, pad);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
